// File: rtl/time_manage_pkg.sv
// Shared types and defaults for the timestamp generator.
// State encoding, period/tolerance defaults, sub-second count, record widths.
package time_manage_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2,
        S_LOST  = 2'd3
    } ts_state_e;

    localparam int PERIOD_CLKS_DEF = 2_500_000;
    localparam int TOL_CLKS_DEF    = 1_000;
    localparam int SUB_PER_SEC_DEF = 40;
    localparam int FRAME_W_DEF     = 32;
    localparam int SEC_W           = 32;
    localparam int SUB_W           = 6;
    localparam int DROP_W          = 16;

    function automatic int ts_rec_w(input int frame_w);
        return frame_w + SEC_W + SUB_W;
    endfunction

    localparam int TS_W = ts_rec_w(FRAME_W_DEF);

endpackage

// File: rtl/ts_hold_reg.sv
// 1-entry valid/ready holding register; a new load replaces the entry.
// Ports: clk/rst_n, clr, load+din, ready in; valid, dout, ovw (overwrite strobe) out.
module ts_hold_reg #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         ovw
);

    // Loading over an entry the consumer has not taken loses it.
    assign ovw = load && !clr && valid && !ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/time_stamp_gen.sv
// Counts 25 ms period pulses into frame/sec/sub timestamps with a pulse watchdog.
// Ports: sys_clk_i, rst_n_i, align, pulse, ts_ready_i in; ts_* valid/data/flags out.
// Option TIME_STAMP_DROP_CNT_EN adds ts_drop_cnt_o (saturating overwrite count).
module time_stamp_gen
    import time_manage_pkg::*;
#(
    parameter int PERIOD_CLKS = PERIOD_CLKS_DEF,
    parameter int TOL_CLKS    = TOL_CLKS_DEF,
    parameter int SUB_PER_SEC = SUB_PER_SEC_DEF,
    parameter int FRAME_W     = FRAME_W_DEF
) (
    input  logic               sys_clk_i,
    input  logic               rst_n_i,
    input  logic               time_period_0_25ms_i,
    input  logic               time_period_25ms_pluse_i,
    input  logic               ts_ready_i,
    output logic               ts_valid_o,
    output logic [FRAME_W-1:0] ts_frame_o,
    output logic [SEC_W-1:0]   ts_sec_o,
    output logic [SUB_W-1:0]   ts_sub_o,
    output logic               ts_overrun_o,
    output logic               ts_lost_o
`ifdef TIME_STAMP_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]  ts_drop_cnt_o
`endif
);

    localparam int REC_W = ts_rec_w(FRAME_W);
    localparam logic [31:0] WD_LIM =
        32'(PERIOD_CLKS + TOL_CLKS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST =
        SUB_W'(SUB_PER_SEC - 1);

    ts_state_e          state_q;
    logic               align_q;
    logic [FRAME_W-1:0] frame_q;
    logic [SEC_W-1:0]   sec_q;
    logic [SUB_W-1:0]   sub_q;
    logic [31:0]        wd_q;
    logic               ovr_q;
    logic               lost_q;
    logic               align_rise;
    logic               run_pulse;
    logic               clr_buf;
    logic               ovw;
    logic [REC_W-1:0]   rec;

    assign align_rise = time_period_0_25ms_i && !align_q;
    assign run_pulse  = (state_q == S_RUN)
                     && time_period_25ms_pluse_i
                     && !time_period_0_25ms_i;
    assign clr_buf    = align_rise || (state_q == S_ALIGN);

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            align_q <= 1'b0;
            frame_q <= '0;
            sec_q   <= '0;
            sub_q   <= '0;
            wd_q    <= '0;
            ovr_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            align_q <= time_period_0_25ms_i;
            if (ovw) begin
                ovr_q <= 1'b1;
            end
            if (align_rise) begin
                state_q <= S_ALIGN;
                frame_q <= '0;
                sec_q   <= '0;
                sub_q   <= '0;
                wd_q    <= '0;
                ovr_q   <= 1'b0;
                lost_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_ALIGN: begin
                        frame_q <= '0;
                        sec_q   <= '0;
                        sub_q   <= '0;
                        wd_q    <= '0;
                        ovr_q   <= 1'b0;
                        lost_q  <= 1'b0;
                        if (!time_period_0_25ms_i) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (run_pulse) begin
                            wd_q    <= '0;
                            frame_q <= frame_q + FRAME_W'(1);
                            if (sub_q == SUB_LAST) begin
                                sub_q <= '0;
                                sec_q <= sec_q + SEC_W'(1);
                            end else begin
                                sub_q <= sub_q + SUB_W'(1);
                            end
                        end else if (wd_q == WD_LIM) begin
                            state_q <= S_LOST;
                            lost_q  <= 1'b1;
                        end else begin
                            wd_q <= wd_q + 32'd1;
                        end
                    end
                    S_LOST: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TIME_STAMP_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_q <= '0;
        end else if (clr_buf) begin
            drop_q <= '0;
        end else if (ovw && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign ts_drop_cnt_o = drop_q;
`endif

    ts_hold_reg #(
        .W (REC_W)
    ) u_hold (
        .clk   (sys_clk_i),
        .rst_n (rst_n_i),
        .clr   (clr_buf),
        .load  (run_pulse),
        .din   ({frame_q, sec_q, sub_q}),
        .ready (ts_ready_i),
        .valid (ts_valid_o),
        .dout  (rec),
        .ovw   (ovw)
    );

    assign ts_frame_o   = rec[REC_W-1 -: FRAME_W];
    assign ts_sec_o     = rec[SUB_W +: SEC_W];
    assign ts_sub_o     = rec[SUB_W-1:0];
    assign ts_overrun_o = ovr_q;
    assign ts_lost_o    = lost_q;

endmodule

// File: tb/tb_time_stamp_gen.sv
// Scoreboard bench for time_stamp_gen with short sim period (2500 + 10).
// Stimulus pushes expected timestamps; a negedge monitor pops on each transfer.
module tb_time_stamp_gen;
    import time_manage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        align = 1'b0;
    logic        pulse = 1'b0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] frame;
    logic [31:0] sec;
    logic [5:0]  sub;
    logic        ovr;
    logic        lost;
`ifdef TIME_STAMP_DROP_CNT_EN
    logic [15:0] drop;
`endif

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] s;
        logic [5:0]  b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    time_stamp_gen #(
        .PERIOD_CLKS (2500),
        .TOL_CLKS    (10),
        .SUB_PER_SEC (40),
        .FRAME_W     (32)
    ) dut (
        .sys_clk_i                (clk),
        .rst_n_i                  (rst_n),
        .time_period_0_25ms_i     (align),
        .time_period_25ms_pluse_i (pulse),
        .ts_ready_i               (ready),
        .ts_valid_o               (valid),
        .ts_frame_o               (frame),
        .ts_sec_o                 (sec),
        .ts_sub_o                 (sub),
        .ts_overrun_o             (ovr),
        .ts_lost_o                (lost)
`ifdef TIME_STAMP_DROP_CNT_EN
        ,
        .ts_drop_cnt_o            (drop)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL ts_extra: got %0d/%0d/%0d want none",
                         frame, sec, sub);
            end else begin
                mon_e = q.pop_front();
                if ({frame, sec, sub} !== mon_e) begin
                    n_bad++;
                    $display("FAIL ts_data: got %0d/%0d/%0d want %0d/%0d/%0d",
                             frame, sec, sub, mon_e.f, mon_e.s, mon_e.b);
                end
            end
        end
    end

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: expect transfer, 1: replaces last expected, 2: never delivered
    task automatic pulse_t(input int f, input int s,
                           input int b, input int mode);
        exp_t e;
        e = '{f: 32'(f), s: 32'(s), b: 6'(b)};
        if (mode == 1 && q.size() > 0) void'(q.pop_back());
        if (mode != 2) q.push_back(e);
        pulse = 1'b1;
        step(1);
        pulse = 1'b0;
    endtask

    task automatic do_align();
        align = 1'b1;
        step(20);
        align = 1'b0;
        step(3);
    endtask

    initial begin
        step(3);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_sec", 64'(sec), 64'd0);
        chk("rst_sub", 64'(sub), 64'd0);
        chk("rst_ovr", 64'(ovr), 64'd0);
        chk("rst_lost", 64'(lost), 64'd0);
        rst_n = 1'b1;
        step(2);

        // idle ignores pulses until align
        pulse_t(0, 0, 0, 2);
        chk("idle_no_valid", 64'(valid), 64'd0);

        // continuous run, ready=1
        do_align();
        ready = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            pulse_t(i, i / 40, i % 40, 0);
            if (i == 0) chk("latency_valid", 64'(valid), 64'd1);
            step(99);
        end
        chk("run_ovr", 64'(ovr), 64'd0);
        chk("run_q_empty", 64'(q.size()), 64'd0);

        // pulse coincident with transfer
        ready = 1'b0;
        pulse_t(41, 1, 1, 0);
        step(10);
        ready = 1'b1;
        pulse_t(42, 1, 2, 0);
        chk("same_cyc_valid", 64'(valid), 64'd1);
        chk("same_cyc_frame", 64'(frame), 64'd42);
        step(5);
        chk("same_cyc_ovr", 64'(ovr), 64'd0);
        chk("same_cyc_q", 64'(q.size()), 64'd0);

        // overwrite while stalled
        ready = 1'b0;
        pulse_t(43, 1, 3, 0);
        step(20);
        pulse_t(44, 1, 4, 1);
        chk("ovw_valid", 64'(valid), 64'd1);
        chk("ovw_frame", 64'(frame), 64'd44);
        step(10);
        chk("ovw_ovr", 64'(ovr), 64'd1);
`ifdef TIME_STAMP_DROP_CNT_EN
        chk("ovw_drop", 64'(drop), 64'd1);
`endif
        ready = 1'b1;
        step(3);
        chk("ovw_drained", 64'(valid), 64'd0);
        chk("ovw_q", 64'(q.size()), 64'd0);

        // align mid-run with pending entry
        ready = 1'b0;
        pulse_t(45, 1, 5, 2);
        chk("pend_valid", 64'(valid), 64'd1);
        align = 1'b1;
        step(1);
        chk("align_clr_valid", 64'(valid), 64'd0);
        chk("align_clr_ovr", 64'(ovr), 64'd0);
        step(10);
        align = 1'b0;
        step(3);
        chk("align_clr_frame", 64'(frame), 64'd0);
        ready = 1'b1;
        pulse_t(0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(99);
            pulse_t(i, 0, i, 0);
        end

        // watchdog: lost rises 2510 cycles after last pulse
        step(2509);
        chk("wd_not_yet", 64'(lost), 64'd0);
        step(1);
        chk("wd_lost", 64'(lost), 64'd1);
        pulse_t(6, 0, 6, 2);
        chk("lost_no_valid", 64'(valid), 64'd0);
        step(5);
        chk("lost_sticky", 64'(lost), 64'd1);
        align = 1'b1;
        step(1);
        chk("lost_clr", 64'(lost), 64'd0);
        step(5);
        align = 1'b0;
        step(3);

        // async reset mid-run with pending entry
        ready = 1'b0;
        pulse_t(0, 0, 0, 2);
        chk("rst2_pend", 64'(valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_valid", 64'(valid), 64'd0);
        chk("rst2_frame", 64'(frame), 64'd0);
        chk("rst2_ovr", 64'(ovr), 64'd0);
        chk("rst2_lost", 64'(lost), 64'd0);
        #3 rst_n = 1'b1;
        step(2);
        pulse_t(0, 0, 0, 2);
        chk("rst2_idle", 64'(valid), 64'd0);
        ready = 1'b1;
        do_align();
        pulse_t(0, 0, 0, 0);
        step(5);
        chk("final_q", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
